// File: rtl/ctrl_cmd_issue_pkg.sv
// Shared types and constants for the DDR4 command-issue stage.
package ctrl_cmd_issue_pkg;

  localparam int unsigned ROW_W      = 15;
  localparam int unsigned COL_W      = 10;
  localparam int unsigned BG_W       = 2;
  localparam int unsigned BA_W       = 2;
  localparam int unsigned BANK_W     = BG_W + BA_W;
  localparam int unsigned A_W        = 14;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned ACT_ADDR_W = BANK_W + ROW_W;
  localparam int unsigned CAS_ADDR_W = BANK_W + COL_W;

  localparam int unsigned T_RCD_DEF  = 16;
  localparam int unsigned T_CCD_DEF  = 4;

  typedef enum logic [1:0] {
    CMD_ACT = 2'd0,
    CMD_PRE = 2'd1,
    CMD_RD  = 2'd2,
    CMD_WR  = 2'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE_PRE = 2'd1,
    ST_ISSUE_ACT = 2'd2,
    ST_ISSUE_CAS = 2'd3
  } issue_fsm_type;

  // {RAS_n, CAS_n, WE_n} encodings for the non-ACT commands
  localparam logic [2:0] RCW_DES = 3'b111;
  localparam logic [2:0] RCW_PRE = 3'b010;
  localparam logic [2:0] RCW_RD  = 3'b101;
  localparam logic [2:0] RCW_WR  = 3'b100;

  typedef struct packed {
    logic [BG_W-1:0]  bg;
    logic [BA_W-1:0]  ba;
  } pre_req_t;

  typedef struct packed {
    logic [BG_W-1:0]  bg;
    logic [BA_W-1:0]  ba;
    logic [ROW_W-1:0] row;
  } act_req_t;

  typedef struct packed {
    logic             rw;
    logic             hit;
    logic [BG_W-1:0]  bg;
    logic [BA_W-1:0]  ba;
    logic [COL_W-1:0] col;
  } cas_req_t;

  typedef struct packed {
    logic             cs_n;
    logic             act_n;
    logic [2:0]       rcw;
    logic [BG_W-1:0]  bg;
    logic [BA_W-1:0]  ba;
    logic [A_W-1:0]   a;
  } ddr_pins_t;

  localparam ddr_pins_t PINS_DES = '{cs_n: 1'b1, act_n: 1'b1, rcw: RCW_DES,
                                     bg: '0, ba: '0, a: '0};

  // Saturating increment: counters stick at all-ones and never wrap
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ctrl_cmd_issue_if.sv
// Request handshake and DDR4 command-pin bundle of the command-issue stage.
interface ctrl_cmd_issue_if;
  import ctrl_cmd_issue_pkg::*;

  logic                  act_rdy;
  logic [ACT_ADDR_W-1:0] act_addr;
  logic                  pre_rdy;
  logic [BANK_W-1:0]     pre_addr;
  logic                  cas_rdy;
  logic                  cas_rw;
  logic [CAS_ADDR_W-1:0] cas_addr;
  logic                  no_act_rdy;

  logic                  CS_n;
  logic                  ACT_n;
  logic                  RAS_n_A16;
  logic                  CAS_n_A15;
  logic                  WE_n_A14;
  logic [BG_W-1:0]       BG;
  logic [BA_W-1:0]       BA;
  logic [A_W-1:0]        A;
  logic                  cmd_issued;
  logic [1:0]            cmd_type;
  logic                  req_overflow;

  modport master (
    output act_rdy, act_addr, pre_rdy, pre_addr, cas_rdy, cas_rw, cas_addr, no_act_rdy,
    input  CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14, BG, BA, A,
    input  cmd_issued, cmd_type, req_overflow
  );

  modport slave (
    input  act_rdy, act_addr, pre_rdy, pre_addr, cas_rdy, cas_rw, cas_addr, no_act_rdy,
    output CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14, BG, BA, A,
    output cmd_issued, cmd_type, req_overflow
  );
endinterface

// File: rtl/ctrl_cmd_issue_slot.sv
// One-deep request slot: pending flag plus captured payload, overflow on a
// request that arrives while the slot is still occupied.
module ctrl_cmd_slot #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_set,
  input  logic [W-1:0] i_data,
  input  logic         i_clr,
  output logic         o_pending,
  output logic [W-1:0] o_data,
  output logic         o_overflow_c
);

  logic         r_pending;
  logic [W-1:0] r_data;

  // A request into an occupied slot is dropped; the first payload is kept
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= 1'b0;
      r_data    <= '0;
    end else if (i_set && !r_pending) begin
      r_pending <= 1'b1;
      r_data    <= i_data;
    end else if (i_clr) begin
      r_pending <= 1'b0;
    end
  end

  assign o_pending    = r_pending;
  assign o_data       = r_data;
  assign o_overflow_c = i_set & r_pending;

endmodule

// File: rtl/ctrl_cmd_issue.sv
// DDR4 command-issue stage: latches PRE/ACT/CAS requests, arbitrates them
// PRE > ACT > CAS, enforces tRCD and tCCD, and drives one registered command
// per clock (DES when nothing is eligible).
module ctrl_cmd_issue
  import ctrl_cmd_issue_pkg::*;
#(
  parameter int unsigned T_RCD = T_RCD_DEF,
  parameter int unsigned T_CCD = T_CCD_DEF
) (
  input logic             CK_t,
  input logic             reset,
  ctrl_cmd_issue_if.slave bus
);

  issue_fsm_type   r_state;
  issue_fsm_type   w_state_nxt;
  ddr_pins_t       r_pins;
  ddr_pins_t       w_pins_nxt;
  cmd_type_e       r_cmd_type;
  cmd_type_e       w_type_nxt;
  logic            r_req_overflow;
  logic [CNT_W-1:0]  r_rcd_cnt;
  logic [CNT_W-1:0]  r_ccd_cnt;
  logic [BANK_W-1:0] r_last_act_bank;

  logic      w_pre_pend, w_act_pend, w_cas_pend;
  logic      w_pre_ovf, w_act_ovf, w_cas_ovf;
  logic      w_clr_pre, w_clr_act, w_clr_cas;
  pre_req_t  w_pre;
  act_req_t  w_act;
  cas_req_t  w_cas;
  logic [16:0] w_row_ext;
  logic      w_bank_diff;
  logic      w_cas_elig;

  ctrl_cmd_slot #(.W($bits(pre_req_t))) u_pre_slot (
    .i_clk(CK_t), .i_rst(reset), .i_set(bus.pre_rdy), .i_data(bus.pre_addr),
    .i_clr(w_clr_pre), .o_pending(w_pre_pend), .o_data(w_pre), .o_overflow_c(w_pre_ovf)
  );

  ctrl_cmd_slot #(.W($bits(act_req_t))) u_act_slot (
    .i_clk(CK_t), .i_rst(reset), .i_set(bus.act_rdy), .i_data(bus.act_addr),
    .i_clr(w_clr_act), .o_pending(w_act_pend), .o_data(w_act), .o_overflow_c(w_act_ovf)
  );

  ctrl_cmd_slot #(.W($bits(cas_req_t))) u_cas_slot (
    .i_clk(CK_t), .i_rst(reset), .i_set(bus.cas_rdy),
    .i_data({bus.cas_rw, bus.no_act_rdy, bus.cas_addr}),
    .i_clr(w_clr_cas), .o_pending(w_cas_pend), .o_data(w_cas), .o_overflow_c(w_cas_ovf)
  );

  // Row bits above ROW_W read as zero on the A16..A14 pins
  assign w_row_ext   = 17'(w_act.row);
  assign w_bank_diff = ({w_cas.bg, w_cas.ba} != r_last_act_bank);
  assign w_cas_elig  = w_cas_pend
                     && (r_ccd_cnt >= CNT_W'(T_CCD - 1))
                     && (w_cas.hit || (r_rcd_cnt >= CNT_W'(T_RCD - 1)) || w_bank_diff);

  // Issue decision: highest-priority eligible slot, its pin image and slot clear
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_pins_nxt  = PINS_DES;
    w_type_nxt  = CMD_ACT;
    w_clr_pre   = 1'b0;
    w_clr_act   = 1'b0;
    w_clr_cas   = 1'b0;
    if (w_pre_pend) begin
      w_state_nxt = ST_ISSUE_PRE;
    end else if (w_act_pend) begin
      w_state_nxt = ST_ISSUE_ACT;
    end else if (w_cas_elig) begin
      w_state_nxt = ST_ISSUE_CAS;
    end
    case (w_state_nxt)
      ST_ISSUE_PRE: begin
        w_clr_pre  = 1'b1;
        w_type_nxt = CMD_PRE;
        w_pins_nxt = '{cs_n: 1'b0, act_n: 1'b1, rcw: RCW_PRE,
                       bg: w_pre.bg, ba: w_pre.ba, a: '0};
      end
      ST_ISSUE_ACT: begin
        w_clr_act  = 1'b1;
        w_type_nxt = CMD_ACT;
        w_pins_nxt = '{cs_n: 1'b0, act_n: 1'b0, rcw: w_row_ext[16:14],
                       bg: w_act.bg, ba: w_act.ba, a: w_row_ext[13:0]};
      end
      ST_ISSUE_CAS: begin
        w_clr_cas  = 1'b1;
        w_type_nxt = w_cas.rw ? CMD_RD : CMD_WR;
        w_pins_nxt = '{cs_n: 1'b0, act_n: 1'b1, rcw: (w_cas.rw ? RCW_RD : RCW_WR),
                       bg: w_cas.bg, ba: w_cas.ba, a: A_W'(w_cas.col)};
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Registered command pins and command type, one cycle per issue
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      r_pins     <= PINS_DES;
      r_cmd_type <= CMD_ACT;
    end else begin
      r_pins     <= w_pins_nxt;
      r_cmd_type <= w_type_nxt;
    end
  end

  // tRCD / tCCD timers, restarted by the command they time from
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      r_rcd_cnt       <= '1;
      r_ccd_cnt       <= '1;
      r_last_act_bank <= '0;
    end else begin
      if (w_state_nxt == ST_ISSUE_ACT) begin
        r_rcd_cnt       <= '0;
        r_last_act_bank <= {w_act.bg, w_act.ba};
      end else begin
        r_rcd_cnt <= sat_inc(r_rcd_cnt);
      end
      if (w_state_nxt == ST_ISSUE_CAS) r_ccd_cnt <= '0;
      else                             r_ccd_cnt <= sat_inc(r_ccd_cnt);
    end
  end

  // Sticky overflow flag across all three slots
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) r_req_overflow <= 1'b0;
    else       r_req_overflow <= r_req_overflow | w_pre_ovf | w_act_ovf | w_cas_ovf;
  end

  assign bus.CS_n         = r_pins.cs_n;
  assign bus.ACT_n        = r_pins.act_n;
  assign bus.RAS_n_A16    = r_pins.rcw[2];
  assign bus.CAS_n_A15    = r_pins.rcw[1];
  assign bus.WE_n_A14     = r_pins.rcw[0];
  assign bus.BG           = r_pins.bg;
  assign bus.BA           = r_pins.ba;
  assign bus.A            = r_pins.a;
  assign bus.cmd_issued   = (r_state != ST_IDLE);
  assign bus.cmd_type     = r_cmd_type;
  assign bus.req_overflow = r_req_overflow;

endmodule

// File: tb/tb_ctrl_cmd_issue.sv
// Directed bench for ctrl_cmd_issue: a per-cycle vector table plus hand-written
// sequences for tRCD, tCCD, overflow and reset-while-pending.
module tb_ctrl_cmd_issue;

  typedef struct packed {
    logic        pre;
    logic [3:0]  pre_a;
    logic        act;
    logic [18:0] act_a;
    logic        cas;
    logic        rw;
    logic [13:0] cas_a;
    logic        hit;
  } stim_t;

  typedef struct packed {
    logic        iss;
    logic [1:0]  typ;
    logic        act_n;
    logic [2:0]  rcw;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [13:0] a;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  localparam int NVEC = 24;

  logic CK_t;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_bad;

  ctrl_cmd_issue_if bus ();

  ctrl_cmd_issue dut (
    .CK_t  (CK_t),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    CK_t = 1'b0;
    forever #5 CK_t = ~CK_t;
  end

  initial cyc = 0;
  always @(posedge CK_t) cyc <= cyc + 1;

  function automatic exp_t x_des();
    return '{iss: 1'b0, typ: 2'd0, act_n: 1'b1, rcw: 3'b111, bg: 2'd0, ba: 2'd0, a: 14'd0};
  endfunction

  function automatic exp_t x_act(input logic [1:0] bg, input logic [1:0] ba, input logic [14:0] row);
    return '{iss: 1'b1, typ: 2'd0, act_n: 1'b0, rcw: {2'b00, row[14]}, bg: bg, ba: ba, a: row[13:0]};
  endfunction

  function automatic exp_t x_pre(input logic [1:0] bg, input logic [1:0] ba);
    return '{iss: 1'b1, typ: 2'd1, act_n: 1'b1, rcw: 3'b010, bg: bg, ba: ba, a: 14'd0};
  endfunction

  function automatic exp_t x_cas(input logic rd, input logic [1:0] bg, input logic [1:0] ba,
                                 input logic [9:0] col);
    return '{iss: 1'b1, typ: (rd ? 2'd2 : 2'd3), act_n: 1'b1, rcw: (rd ? 3'b101 : 3'b100),
             bg: bg, ba: ba, a: {4'b0000, col}};
  endfunction

  function automatic stim_t s_none();
    return '0;
  endfunction

  function automatic logic [26:0] observe();
    return {bus.CS_n, bus.ACT_n, bus.RAS_n_A16, bus.CAS_n_A15, bus.WE_n_A14,
            bus.BG, bus.BA, bus.A, bus.cmd_issued,
            (bus.cmd_issued ? bus.cmd_type : 2'b00), bus.req_overflow};
  endfunction

  function automatic logic [26:0] expect_of(input exp_t e, input logic ovf);
    return {~e.iss, e.act_n, e.rcw, e.bg, e.ba, e.a, e.iss, e.typ, ovf};
  endfunction

  task automatic drive(input stim_t s);
    bus.pre_rdy    = s.pre;
    bus.pre_addr   = s.pre_a;
    bus.act_rdy    = s.act;
    bus.act_addr   = s.act_a;
    bus.cas_rdy    = s.cas;
    bus.cas_rw     = s.rw;
    bus.cas_addr   = s.cas_a;
    bus.no_act_rdy = s.hit;
  endtask

  task automatic tick();
    @(posedge CK_t);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic apply_reset();
    drive(s_none());
    reset = 1'b1;
    @(posedge CK_t);
    @(posedge CK_t);
    #1;
    reset = 1'b0;
  endtask

  // Waits up to budget cycles for a cmd_issued pulse, returning at that negedge
  task automatic wait_cmd(input int budget, output bit found, output int at_cyc);
    found  = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge CK_t);
      if (bus.cmd_issued === 1'b1) begin
        found  = 1'b1;
        at_cyc = cyc;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs [NVEC];
    stim_t s;
    bit    f;
    int    p, c1, c2;

    n_vec = 0;
    n_bad = 0;

    for (int i = 0; i < NVEC; i++) vecs[i] = '{s: s_none(), e: x_des()};

    s = s_none(); s.act = 1'b1; s.act_a = {2'd1, 2'd2, 15'h1234};
    vecs[0].s = s;
    vecs[2].e = x_act(2'd1, 2'd2, 15'h1234);

    s = s_none();
    s.pre = 1'b1; s.pre_a = {2'd0, 2'd1};
    s.act = 1'b1; s.act_a = {2'd3, 2'd3, 15'h5ABC};
    s.cas = 1'b1; s.rw = 1'b1; s.cas_a = {2'd3, 2'd3, 10'h155}; s.hit = 1'b1;
    vecs[3].s = s;
    vecs[5].e = x_pre(2'd0, 2'd1);
    vecs[6].e = x_act(2'd3, 2'd3, 15'h5ABC);
    vecs[7].e = x_cas(1'b1, 2'd3, 2'd3, 10'h155);

    s = s_none(); s.cas = 1'b1; s.rw = 1'b0; s.cas_a = {2'd1, 2'd1, 10'h3FF}; s.hit = 1'b1;
    vecs[8].s  = s;
    vecs[11].e = x_cas(1'b0, 2'd1, 2'd1, 10'h3FF);

    s = s_none(); s.cas = 1'b1; s.rw = 1'b1; s.cas_a = {2'd0, 2'd1, 10'h0AA};
    vecs[13].s = s;
    vecs[15].e = x_cas(1'b1, 2'd0, 2'd1, 10'h0AA);

    s = s_none(); s.cas = 1'b1; s.rw = 1'b1; s.cas_a = {2'd3, 2'd3, 10'h001};
    vecs[16].s = s;
    vecs[22].e = x_cas(1'b1, 2'd3, 2'd3, 10'h001);

    reset = 1'b1;
    drive(s_none());
    @(posedge CK_t);
    @(posedge CK_t);
    @(negedge CK_t);
    chk("reset_idle", 32'(observe()), 32'(expect_of(x_des(), 1'b0)));
    @(posedge CK_t);
    #1;
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].s);
      @(negedge CK_t);
      chk($sformatf("vec%0d", i), 32'(observe()), 32'(expect_of(vecs[i].e, 1'b0)));
      tick();
    end
    drive(s_none());

    // ACT then same-bank RD without row hit: RD exactly tRCD after ACT
    apply_reset();
    p = cyc;
    s = s_none(); s.act = 1'b1; s.act_a = {2'd0, 2'd0, 15'h0042};
    drive(s);
    tick();
    s = s_none(); s.cas = 1'b1; s.rw = 1'b1; s.cas_a = {2'd0, 2'd0, 10'h2C3};
    drive(s);
    tick();
    drive(s_none());
    wait_cmd(10, f, c1);
    chk("trcd_act_seen", 32'(f), 32'd1);
    chk("trcd_act_latency", 32'(c1 - p), 32'd2);
    chk("trcd_act_type", 32'(bus.cmd_type), 32'd0);
    wait_cmd(40, f, c2);
    chk("trcd_rd_seen", 32'(f), 32'd1);
    chk("trcd_gap", 32'(c2 - c1), 32'd16);
    chk("trcd_rd_col", 32'(bus.A[9:0]), 32'h2C3);
    chk("trcd_rd_type", 32'(bus.cmd_type), 32'd2);

    // Row-hit CAS right after reset, then a second CAS: tCCD spacing
    apply_reset();
    p = cyc;
    s = s_none(); s.cas = 1'b1; s.rw = 1'b1; s.cas_a = {2'd1, 2'd3, 10'h010}; s.hit = 1'b1;
    drive(s);
    tick();
    drive(s_none());
    tick();
    s = s_none(); s.cas = 1'b1; s.rw = 1'b1; s.cas_a = {2'd1, 2'd3, 10'h020}; s.hit = 1'b1;
    drive(s);
    @(negedge CK_t);
    chk("ccd_first_rd", 32'(observe()),
        32'(expect_of(x_cas(1'b1, 2'd1, 2'd3, 10'h010), 1'b0)));
    c1 = cyc;
    chk("ccd_first_latency", 32'(c1 - p), 32'd2);
    tick();
    drive(s_none());
    wait_cmd(10, f, c2);
    chk("ccd_second_seen", 32'(f), 32'd1);
    chk("ccd_gap", 32'(c2 - c1), 32'd4);
    chk("ccd_second_rd", 32'(observe()),
        32'(expect_of(x_cas(1'b1, 2'd1, 2'd3, 10'h020), 1'b0)));

    // Two ACT requests before issue: first kept, sticky overflow, no second ACT
    apply_reset();
    p = cyc;
    s = s_none(); s.act = 1'b1; s.act_a = {2'd2, 2'd1, 15'h0111};
    drive(s);
    tick();
    s = s_none(); s.act = 1'b1; s.act_a = {2'd1, 2'd1, 15'h0222};
    drive(s);
    tick();
    drive(s_none());
    wait_cmd(10, f, c1);
    chk("ovf_act_latency", 32'(c1 - p), 32'd2);
    chk("ovf_act_pins", 32'(observe()),
        32'(expect_of(x_act(2'd2, 2'd1, 15'h0111), 1'b1)));
    wait_cmd(20, f, c2);
    chk("ovf_no_second_act", 32'(f), 32'd0);
    chk("ovf_sticky", 32'(bus.req_overflow), 32'd1);

    // Reset while ACT is on the pins and a CAS is still pending
    apply_reset();
    s = s_none();
    s.act = 1'b1; s.act_a = {2'd0, 2'd2, 15'h0333};
    s.cas = 1'b1; s.rw = 1'b1; s.cas_a = {2'd0, 2'd2, 10'h005}; s.hit = 1'b1;
    drive(s);
    tick();
    drive(s_none());
    tick();
    chk("rst_mid_act_on_pins", 32'(bus.cmd_issued), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_des", 32'(observe()), 32'(expect_of(x_des(), 1'b0)));
    @(posedge CK_t);
    @(posedge CK_t);
    #1;
    reset = 1'b0;
    wait_cmd(30, f, c1);
    chk("rst_mid_no_issue", 32'(f), 32'd0);
    chk("rst_mid_idle_pins", 32'(observe()), 32'(expect_of(x_des(), 1'b0)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
